// File: rtl/clock_ctrl.sv
// Hours/minutes/seconds timekeeper with a button-driven set mode.
// Drives per-field blanking so the display stage can blink the field being edited.
module clock_ctrl #(
  parameter int MAX_S = 59,
  parameter int MAX_M = 59,
  parameter int MAX_H = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [5:0] cnt_s,
  output logic [5:0] cnt_m,
  output logic [4:0] cnt_h,
  output logic [1:0] mode,
  output logic       blank_h,
  output logic       blank_m,
  output logic       blank_s,
  output logic       day_pulse
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } mode_t;

  localparam logic [5:0] LAST_S = 6'(MAX_S);
  localparam logic [5:0] LAST_M = 6'(MAX_M);
  localparam logic [4:0] LAST_H = 5'(MAX_H);

  mode_t      state_reg, state_next;
  logic [5:0] s_reg, s_next;
  logic [5:0] m_reg, m_next;
  logic [4:0] h_reg, h_next;
  logic       blink_reg, blink_next;
  logic       blank_h_reg, blank_h_next;
  logic       blank_m_reg, blank_m_next;
  logic       blank_s_reg, blank_s_next;
  logic       day_reg, day_next;

  logic s_last, m_last, h_last;
  logic inc_ok;

  assign s_last = (s_reg == LAST_S);
  assign m_last = (m_reg == LAST_M);
  assign h_last = (h_reg == LAST_H);
  // A mode press in the same cycle swallows the increment.
  assign inc_ok = btn_inc & ~btn_mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= RUN;
      s_reg       <= '0;
      m_reg       <= '0;
      h_reg       <= '0;
      blink_reg   <= 1'b0;
      blank_h_reg <= 1'b0;
      blank_m_reg <= 1'b0;
      blank_s_reg <= 1'b0;
      day_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      s_reg       <= s_next;
      m_reg       <= m_next;
      h_reg       <= h_next;
      blink_reg   <= blink_next;
      blank_h_reg <= blank_h_next;
      blank_m_reg <= blank_m_next;
      blank_s_reg <= blank_s_next;
      day_reg     <= day_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    m_next     = m_reg;
    h_next     = h_reg;
    day_next   = 1'b0;
    blink_next = blink_reg;

    if (btn_mode) begin
      case (state_reg)
        RUN:     state_next = SET_H;
        SET_H:   state_next = SET_M;
        SET_M:   state_next = SET_S;
        default: state_next = RUN;
      endcase
    end

    case (state_reg)
      RUN: begin
        // Ripple carry through the fields; only a full-day wrap raises day_pulse.
        if (tick) begin
          s_next = s_last ? 6'd0 : s_reg + 6'd1;
          if (s_last) begin
            m_next = m_last ? 6'd0 : m_reg + 6'd1;
            if (m_last) begin
              h_next   = h_last ? 5'd0 : h_reg + 5'd1;
              day_next = h_last;
            end
          end
        end
      end
      SET_H: if (inc_ok) h_next = h_last ? 5'd0 : h_reg + 5'd1;
      SET_M: if (inc_ok) m_next = m_last ? 6'd0 : m_reg + 6'd1;
      default: if (inc_ok) s_next = s_last ? 6'd0 : s_reg + 6'd1;
    endcase

    if (btn_mode || state_reg == RUN) begin
      blink_next = 1'b0;
    end else if (tick) begin
      blink_next = ~blink_reg;
    end

    // Registered from next-state values so blanking lines up with mode.
    blank_h_next = blink_next && (state_next == SET_H);
    blank_m_next = blink_next && (state_next == SET_M);
    blank_s_next = blink_next && (state_next == SET_S);
  end

  assign cnt_s     = s_reg;
  assign cnt_m     = m_reg;
  assign cnt_h     = h_reg;
  assign mode      = state_reg;
  assign blank_h   = blank_h_reg;
  assign blank_m   = blank_m_reg;
  assign blank_s   = blank_s_reg;
  assign day_pulse = day_reg;

endmodule

// File: tb/tb_clock_ctrl.sv
// Scoreboard bench for clock_ctrl: a time-of-day reference model queues the
// expected outputs per cycle and a monitor compares them after each edge.
module tb_clock_ctrl;

  localparam int MAX_S = 59;
  localparam int MAX_M = 59;
  localparam int MAX_H = 23;
  localparam int DAY_SECS = (MAX_H + 1) * (MAX_M + 1) * (MAX_S + 1);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [5:0] cnt_s;
  logic [5:0] cnt_m;
  logic [4:0] cnt_h;
  logic [1:0] mode;
  logic       blank_h, blank_m, blank_s, day_pulse;

  typedef struct packed {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic [1:0] md;
    logic       bh;
    logic       bm;
    logic       bs;
    logic       day;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model state
  int m_h = 0, m_m = 0, m_s = 0, m_mode = 0;
  bit m_blink = 0;

  clock_ctrl #(.MAX_S(MAX_S), .MAX_M(MAX_M), .MAX_H(MAX_H)) dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cnt_s(cnt_s), .cnt_m(cnt_m), .cnt_h(cnt_h), .mode(mode),
    .blank_h(blank_h), .blank_m(blank_m), .blank_s(blank_s), .day_pulse(day_pulse)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    obs_t o;
    o.h = cnt_h; o.m = cnt_m; o.s = cnt_s; o.md = mode;
    o.bh = blank_h; o.bm = blank_m; o.bs = blank_s; o.day = day_pulse;
    return o;
  endfunction

  function automatic obs_t model_obs(bit day);
    obs_t o;
    o.h = 5'(m_h); o.m = 6'(m_m); o.s = 6'(m_s); o.md = 2'(m_mode);
    o.bh = m_blink && m_mode == 1;
    o.bm = m_blink && m_mode == 2;
    o.bs = m_blink && m_mode == 3;
    o.day = day;
    return o;
  endfunction

  task automatic compare(string name, obs_t a, obs_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d got h=%0d m=%0d s=%0d mode=%0d blank=%b%b%b day=%b required h=%0d m=%0d s=%0d mode=%0d blank=%b%b%b day=%b",
               name, cyc, a.h, a.m, a.s, a.md, a.bh, a.bm, a.bs, a.day,
               e.h, e.m, e.s, e.md, e.bh, e.bm, e.bs, e.day);
    end
  endtask

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_blink = 0;
  endtask

  // One clock cycle of stimulus; the model's prediction goes to the scoreboard.
  task automatic step(bit t, bit bm, bit bi);
    int  total;
    bit  day;
    @(negedge clk);
    tick = t; btn_mode = bm; btn_inc = bi;
    day = 0;
    if (m_mode == 0) begin
      if (t) begin
        total = (m_h * (MAX_M + 1) + m_m) * (MAX_S + 1) + m_s;
        total = (total + 1) % DAY_SECS;
        day   = (total == 0);
        m_s   = total % (MAX_S + 1);
        m_m   = (total / (MAX_S + 1)) % (MAX_M + 1);
        m_h   = total / ((MAX_S + 1) * (MAX_M + 1));
      end
    end else if (bi && !bm) begin
      case (m_mode)
        1: m_h = (m_h + 1) % (MAX_H + 1);
        2: m_m = (m_m + 1) % (MAX_M + 1);
        default: m_s = (m_s + 1) % (MAX_S + 1);
      endcase
    end
    if (bm) begin
      m_blink = 0;
      m_mode  = (m_mode + 1) % 4;
    end else if (m_mode != 0 && t) begin
      m_blink = ~m_blink;
    end
    exp_q.push_back(model_obs(day));
  endtask

  // From RUN: walk through the set states, leaving the model in SET_S.
  task automatic set_fields(int h, int m, int s);
    step(0, 1, 0);
    while (m_h != h) step(0, 0, 1);
    step(0, 1, 0);
    while (m_m != m) step(0, 0, 1);
    step(0, 1, 0);
    while (m_s != s) step(0, 0, 1);
  endtask

  task automatic set_time(int h, int m, int s);
    set_fields(h, m, s);
    step(0, 1, 0);
  endtask

  // Monitor: every cycle the DUT presents a new output word.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare("scoreboard", observe(), e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    #3;
    compare("reset_state", observe(), model_obs(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 61 ticks in RUN
    repeat (61) step(1, 0, 0);

    // Preload 23:59:58, then two ticks into the day rollover
    set_time(23, 59, 58);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);

    // SET_H: 25 increments wrap hours to 1; ticks blink but do not count
    step(0, 1, 0);
    repeat (25) step(0, 0, 1);
    repeat (5) step(1, 0, 0);
    step(1, 0, 1);
    step(0, 0, 0);

    // SET_M: wrap 59 -> 0, then mode+inc together
    step(0, 1, 0);
    while (m_m != MAX_M) step(0, 0, 1);
    step(0, 0, 1);
    step(1, 0, 0);
    step(0, 1, 1);
    step(0, 1, 0);

    // RUN at 00:00:59: tick and mode in the same cycle
    set_time(0, 0, 59);
    step(1, 1, 0);
    step(1, 0, 0);
    repeat (3) step(0, 1, 0);

    // btn_inc in RUN is ignored
    repeat (4) step(0, 0, 1);

    // Async reset in SET_S at 12:34:56
    set_fields(12, 34, 56);
    step(1, 0, 0);
    @(posedge clk);
    #3;
    tick = 0; btn_mode = 0; btn_inc = 0;
    rst = 1'b1;
    #1;
    model_reset();
    compare("async_reset", observe(), model_obs(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step(1, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
    end

    step(0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain got %0d entries left required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
- Timekeeping and time-set controller for the digital clock.
- Holds the hours, minutes and seconds counters and advances them on a 1 Hz enable. Runs a button-driven set-mode state machine.
- Drives per-field blanking so the seven-segment decoder stage can blink the field being edited.
- Sits between the debounced button/tick sources and the per-field seven-segment decoders. cnt_s feeds the seconds decoder directly.

Parameters:
- MAX_S, 59, last seconds value before wrap (must be <= 63)
- MAX_M, 59, last minutes value before wrap (must be <= 63)
- MAX_H, 23, last hours value before wrap (must be <= 31)

Ports:
- clk  in  1  system clock; all state changes on posedge
- rst  in  1  asynchronous, active-high reset
- tick  in  1  1 Hz enable; single-cycle pulse, synchronous to clk
- btn_mode  in  1  debounced single-cycle pulse; advances set-mode state
- btn_inc  in  1  debounced single-cycle pulse; increments field under edit
- cnt_s  out  6  seconds, 0..MAX_S
- cnt_m  out  6  minutes, 0..MAX_M
- cnt_h  out  5  hours, 0..MAX_H
- mode  out  2  FSM state: 0=RUN, 1=SET_H, 2=SET_M, 3=SET_S
- blank_h / blank_m / blank_s  out  1 each  blank request for that field's display, 1 = blank
- day_pulse  out  1  one-cycle pulse on MAX_H:MAX_M:MAX_S -> 0:0:0 rollover in RUN

Behaviour:
- Reset (async, rst=1):
  - cnt_s=cnt_m=cnt_h=0, mode=RUN, blink=0.
  - All blank_*=0, day_pulse=0.
  - rst asserted mid-edit returns to RUN at 00:00:00 immediately. Deassertion is a synchronous release: the first edge with rst=0 performs normal operation.
- All outputs are registered. Counter and mode updates are visible one cycle after the causing input edge.
- RUN state, on tick=1:
  - cnt_s==MAX_S -> cnt_s=0 with carry to minutes; else cnt_s+1.
  - Minutes increment only on seconds carry; cnt_m==MAX_M with carry -> cnt_m=0 with carry to hours.
  - Hours increment only on minutes carry; cnt_h==MAX_H with carry -> cnt_h=0, day_pulse=1 for that one cycle.
  - tick=0 -> counters hold.
- FSM transitions, on btn_mode=1: RUN->SET_H->SET_M->SET_S->RUN. No other transitions.
- Set states:
  - tick never advances counters.
  - btn_inc increments only the selected field, wrapping MAX->0 with no carry into other fields. cnt_s does not clear on entry.
- Simultaneous events:
  - btn_mode and btn_inc in the same cycle: mode transition taken, btn_inc dropped.
  - tick and btn_mode in RUN in the same cycle: tick counted (including any carry and day_pulse), and mode becomes SET_H.
  - tick and btn_inc in a set state: only btn_inc acts.
  - btn_inc in RUN: ignored.
- Blink:
  - Internal blink bit cleared on every mode change and held at 0 in RUN.
  - In set states it toggles on each tick.
  - blank_x = blink AND (mode==SET_x). At most one blank_* is high at any time.
- day_pulse: asserted only by RUN rollover, never by set-mode wraps.
- Widths: counter compares use the full field width. No out-of-range value is reachable from any legal input sequence.

Test Plan:
- Reset then 61 ticks in RUN -> cnt_s=1, cnt_m=1, cnt_h=0, mode=0, all blank_*=0.
- Preload to 23:59:58 via set mode, return to RUN, 2 ticks -> 00:00:00 after second tick, day_pulse high exactly one cycle.
- btn_mode x1, then 25 btn_inc pulses -> cnt_h=1 (wraps at 24), cnt_m/cnt_s unchanged. Ticks in this state leave counters unchanged, and blank_h toggles on each tick.
- In SET_M with cnt_m=59, btn_inc -> cnt_m=0, cnt_h unchanged. btn_mode and btn_inc in the same cycle -> mode=3, cnt_s unchanged.
- In RUN at 00:00:59, tick and btn_mode in the same cycle -> 00:01:00 and mode=1, blink=0.
- Assert rst asynchronously (between clk edges) while in SET_S at 12:34:56 -> outputs immediately 00:00:00, mode=0, all blank_*=0.
